// File: rtl/nibble_accumulator_pkg.sv
// Shared definitions for the nibble accumulator: FSM state encoding and
// default widths used by the top level and its adder.
package nibble_accumulator_pkg;

    localparam int unsigned ACC_W_DEFAULT = 8;
    localparam int unsigned NIBBLE_W      = 4;
    localparam int unsigned BEAT_W        = NIBBLE_W + 1;
    localparam int unsigned LEN_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_accumulator_ripple_add4.sv
// 4-bit ripple-carry adder producing the per-beat sum a + b + cin.
module ripple_add4
    import nibble_accumulator_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_accumulator.sv
// Burst accumulator: sums len beats of (a + b + cin) into an ACC_W-bit
// result with sticky overflow, reporting completion with a one-cycle done.
module nibble_accumulator
    import nibble_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             cin,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             done
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic               ovf_q,   ovf_d;
    logic [LEN_W-1:0]   cnt_q,   cnt_d;

    logic [NIBBLE_W-1:0] beat_lo;
    logic                beat_cout;
    logic [ACC_W:0]      sum_full;
    logic                beat_accept;

    ripple_add4 u_add (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (beat_lo),
        .cout (beat_cout)
    );

    // Extra top bit of sum_full is the carry out of the accumulator MSB.
    assign sum_full    = {1'b0, acc_q} + {{(ACC_W - NIBBLE_W){1'b0}}, beat_cout, beat_lo};
    assign beat_accept = in_valid && (state_q == ST_ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (beat_accept) begin
                    acc_d = sum_full[ACC_W-1:0];
                    ovf_d = ovf_q | sum_full[ACC_W];
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready = (state_q == ST_ACCUM);
    assign done     = (state_q == ST_DONE);
    assign acc_out  = acc_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_nibble_accumulator.sv
// Self-checking bench for nibble_accumulator: table vectors, hand-written
// corner sequences and randomized bursts against a plain-arithmetic model.
module tb_nibble_accumulator;

    localparam int ACC_W = 8;
    localparam int MOD   = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       len;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             cin;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic             done;

    int checks = 0;
    int errors = 0;

    nibble_accumulator #(.ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .acc_out  (acc_out),
        .ovf      (ovf),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        len;
        logic [14:0][3:0]  va;
        logic [14:0][3:0]  vb;
        logic [14:0]       vc;
        logic [7:0]        exp_acc;
        logic              exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Runs one burst; the model is simply the integer total of all beats.
    task automatic run_burst(input logic [3:0] blen,
                             input logic [14:0][3:0] va,
                             input logic [14:0][3:0] vb,
                             input logic [14:0] vc,
                             input int gap_pct,
                             input bit poke_start,
                             output logic [ACC_W-1:0] racc,
                             output logic rovf);
        int total;
        int i;
        logic [ACC_W-1:0] held;
        total = 0;
        i = 0;
        @(negedge clk);
        start = 1'b1; len = blen; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("start_acc_clear", acc_out, 0);
        chk("start_ovf_clear", ovf, 0);
        if (blen == 0) begin
            chk("len0_done", done, 1);
            chk("len0_ready", in_ready, 0);
        end else begin
            chk("accum_done_low", done, 0);
            while (i < int'(blen)) begin
                @(negedge clk);
                start = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
                len = 4'($urandom);
                chk("ready_in_accum", in_ready, 1);
                if (int'($urandom_range(0, 99)) < gap_pct) begin
                    in_valid = 1'b0;
                    a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
                end else begin
                    in_valid = 1'b1;
                    a = va[i]; b = vb[i]; cin = vc[i];
                    total += int'(a) + int'(b) + int'(cin);
                    i++;
                end
                @(posedge clk); #1;
                chk("acc_running", acc_out, total % MOD);
                chk("ovf_running", ovf, (total >= MOD) ? 1 : 0);
                if (i < int'(blen) || !in_valid) chk("done_early", done, 0);
                else chk("done_after_last", done, 1);
            end
        end
        racc = acc_out;
        rovf = ovf;
        held = acc_out;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a = 4'($urandom); b = 4'($urandom);
        @(posedge clk); #1;
        chk("idle_done_low", done, 0);
        chk("idle_ready_low", in_ready, 0);
        chk("idle_acc_hold", acc_out, held);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    vec_t vecs[4];
    logic [ACC_W-1:0] r_acc;
    logic r_ovf;
    logic [14:0][3:0] ra, rb;
    logic [14:0] rc;

    initial begin
        rst = 1'b1; start = 1'b1; len = 4'd3; in_valid = 1'b1;
        a = 4'd1; b = 4'd1; cin = 1'b1;
        vecs[0] = '{len: 4'd1, va: {14'd0, 4'd5}, vb: {14'd0, 4'd3}, vc: 15'd0,
                    exp_acc: 8'd8, exp_ovf: 1'b0};
        vecs[1] = '{len: 4'd3, va: '0, vb: '0, vc: 15'b110, exp_acc: 8'd57, exp_ovf: 1'b0};
        vecs[1].va[0] = 4'd15; vecs[1].vb[0] = 4'd1;
        vecs[1].va[1] = 4'd10; vecs[1].vb[1] = 4'd5;
        vecs[1].va[2] = 4'd12; vecs[1].vb[2] = 4'd12;
        vecs[2] = '{len: 4'd0, va: '0, vb: '0, vc: '0, exp_acc: 8'd0, exp_ovf: 1'b0};
        vecs[3] = '{len: 4'd15, va: {15{4'hF}}, vb: {15{4'hF}}, vc: {15{1'b1}},
                    exp_acc: 8'd209, exp_ovf: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_acc", acc_out, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_ready", in_ready, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;

        for (int k = 0; k < 4; k++) begin
            run_burst(vecs[k].len, vecs[k].va, vecs[k].vb, vecs[k].vc, 0, 1'b0, r_acc, r_ovf);
            chk("table_acc", r_acc, vecs[k].exp_acc);
            chk("table_ovf", r_ovf, vecs[k].exp_ovf);
        end

        // len=2 with gaps and a stray start pulse; beats 19 + 6 = 25
        @(negedge clk); start = 1'b1; len = 4'd2; in_valid = 1'b0;
        @(negedge clk); start = 1'b1; len = 4'd7; in_valid = 1'b0;
        chk("gap_ready", in_ready, 1);
        @(negedge clk); start = 1'b0; in_valid = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b1;
        @(negedge clk); start = 1'b1; len = 4'd4; in_valid = 1'b0;
        chk("gap_acc_mid", acc_out, 19);
        @(negedge clk); start = 1'b0; in_valid = 1'b1; a = 4'd4; b = 4'd2; cin = 1'b0;
        chk("gap_no_done", done, 0);
        @(posedge clk); #1;
        chk("gap_done", done, 1);
        chk("gap_acc", acc_out, 25);
        chk("gap_ovf", ovf, 0);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_single_done", done, 0);
        chk("gap_back_idle", in_ready, 0);

        // reset partway through a new burst
        @(negedge clk); start = 1'b1; len = 4'd3;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; a = 4'd7; b = 4'd6; cin = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk("prerst_acc", acc_out, 14);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done", done, 0);
        @(negedge clk); rst = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("postrst_no_done", done, 0);
            chk("postrst_acc", acc_out, 0);
            chk("postrst_ready", in_ready, 0);
        end
        @(negedge clk); in_valid = 1'b0;

        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 15; j++) begin
                ra[j] = 4'($urandom);
                rb[j] = 4'($urandom);
                rc[j] = 1'($urandom);
            end
            if (n % 4 == 0) begin
                ra = {15{4'hF}}; rb = {15{4'hE}};
            end
            run_burst(4'($urandom_range(0, 15)), ra, rb, rc, 30, 1'b1, r_acc, r_ovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
